// File: rtl/tx_iq_buf_pkg.sv
// Shared types and defaults for the TX I/Q stream buffer.
package tx_iq_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_STREAM
    } state_t;

    localparam int DEF_IQ_WIDTH = 16;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_PREFILL  = 16;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tx_iq_fifo.sv
// Synchronous FIFO with combinational read port; holds {last, I, Q} entries.
module tx_iq_fifo
    import tx_iq_buf_pkg::*;
#(
    parameter int WIDTH = 2*DEF_IQ_WIDTH+1,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [fill_w(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = fill_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_iq_stream_buf.sv
// TX I/Q stream buffer: prefill a FIFO, then stream one sample per cycle
// to NUM_CH antenna channels with per-channel masking.
module tx_iq_stream_buf
    import tx_iq_buf_pkg::*;
#(
    parameter int IQ_WIDTH = DEF_IQ_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int PREFILL  = DEF_PREFILL
) (
    input  logic                       clk,
    input  logic                       phy_tx_arestn,
    input  logic                       soft_rst,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IQ_WIDTH-1:0]        in_i,
    input  logic [IQ_WIDTH-1:0]        in_q,
    input  logic                       in_last,
    input  logic                       out_hold,
    output logic                       out_valid,
    output logic [NUM_CH*IQ_WIDTH-1:0] out_i,
    output logic [NUM_CH*IQ_WIDTH-1:0] out_q,
    output logic                       tx_started,
    output logic                       tx_done,
    output logic                       underrun,
    output logic [fill_w(DEPTH)-1:0]   fill_level
);
    localparam int            FW          = fill_w(DEPTH);
    localparam int            EW          = 2*IQ_WIDTH + 1;
    localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);

    state_t              state, state_nx;
    logic                last_seen, push, pop, full, empty, rd_last;
    logic [EW-1:0]       rd_data;
    logic [IQ_WIDTH-1:0] rd_i, rd_q;

    assign {rd_last, rd_i, rd_q} = rd_data;
    // Refuse input during any reset so nothing is accepted and then discarded.
    assign in_ready = phy_tx_arestn && !soft_rst && !full && !last_seen;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_STREAM) && !empty && !out_hold;

    tx_iq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (phy_tx_arestn),
        .clr   (soft_rst),
        .push  (push),
        .din   ({in_last, in_i, in_q}),
        .pop   (pop),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) state <= ST_IDLE;
        else if (soft_rst)  state <= ST_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        tx_started = 1'b0;
        case (state)
            ST_IDLE:    if (push) state_nx = ST_PREFILL;
            ST_PREFILL: if (fill_level >= PREFILL_LVL || last_seen) begin
                tx_started = 1'b1;
                state_nx   = ST_STREAM;
            end
            ST_STREAM:  if (pop && rd_last) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // last_seen stays up through the tx_done cycle so the next packet starts after it.
    always_ff @(posedge clk or negedge phy_tx_arestn) begin
        if (!phy_tx_arestn) begin
            last_seen <= 1'b0;
            out_valid <= 1'b0;
            tx_done   <= 1'b0;
            underrun  <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else if (soft_rst) begin
            last_seen <= 1'b0;
            out_valid <= 1'b0;
            tx_done   <= 1'b0;
            underrun  <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            out_valid <= pop;
            tx_done   <= pop && rd_last;
            if (push && in_last) last_seen <= 1'b1;
            else if (tx_done)    last_seen <= 1'b0;
            if (state == ST_STREAM && empty && !out_hold && !last_seen) underrun <= 1'b1;
            if (pop) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    out_i[k*IQ_WIDTH +: IQ_WIDTH] <= ch_en[k] ? rd_i : '0;
                    out_q[k*IQ_WIDTH +: IQ_WIDTH] <= ch_en[k] ? rd_q : '0;
                end
            end
        end
    end

endmodule
